// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scan controller.
//   scan_state_t : scan sequencer states
//   NUM_ROWS / NUM_COLS / KEY_CODE_W : keypad geometry and key code width
//   prio_row()   : index of the lowest set row bit (0 when no bit is set)
package keypad_pkg;

  localparam int NUM_ROWS   = 4;
  localparam int NUM_COLS   = 4;
  localparam int KEY_CODE_W = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } scan_state_t;

  // Lowest-index row wins when several rows read pressed at once.
  function automatic logic [1:0] prio_row(input logic [NUM_ROWS-1:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Multi-stage synchronizer for the asynchronous keypad row lines.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low clear of every stage
//   d     : raw asynchronous input bits
//   q     : d delayed through STAGES flops
module keypad_row_sync #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Stage 0 occupies the low WIDTH bits; the oldest stage sits at the top.
  logic [STAGES*WIDTH-1:0] chain;

  // NOTE: every synchronizer stage is cleared on reset so a stale pre-reset
  // press cannot leak into the scan logic after reset is released; the shift
  // uses non-blocking assignments so each stage takes the previous stage's old
  // value on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[(STAGES-1)*WIDTH-1:0], d};
    end
  end

  assign q = chain[STAGES*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Scan sequencer for a 4x4 matrix keypad.
// Drives one column at a time, samples the synchronized rows on each dwell
// tick, debounces a press, hands the encoded key to the consumer with a
// valid/ack handshake and freezes the scan while the key is held.
// Ports:
//   clk         : system clock, all logic on posedge
//   rst_n_i     : asynchronous active-low reset (asserts async, releases sync)
//   row_i       : raw row lines, 1 = pressed in the driven column
//   col_o       : one-hot active-high column drive
//   key_code_o  : {row_idx, col_idx} of the captured key
//   key_valid_o : key_code_o holds an unconsumed key
//   key_ack_i   : consumer accepts key_code_o
//   key_held_o  : a debounced key is currently held
//   overrun_o   : sticky, a key was debounced while key_valid_o was high
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n_i,
  input  logic [NUM_ROWS-1:0]   row_i,
  output logic [NUM_COLS-1:0]   col_o,
  output logic [KEY_CODE_W-1:0] key_code_o,
  output logic                  key_valid_o,
  input  logic                  key_ack_i,
  output logic                  key_held_o,
  output logic                  overrun_o
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  // Reset release is retimed to clk; assertion still propagates immediately.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  logic [NUM_ROWS-1:0] row_s;

  keypad_row_sync #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (NUM_ROWS)
  ) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row_i),
    .q     (row_s)
  );

  scan_state_t         state;
  logic [1:0]          col_idx;
  logic [DIV_W-1:0]    dwell_cnt;
  logic [DB_W-1:0]     db_cnt;
  logic [NUM_ROWS-1:0] row_latch;
  logic                tick;

  assign tick  = (state == SCAN) && (dwell_cnt == DIV_W'(SCAN_DIV - 1));
  assign col_o = NUM_COLS'(1) << col_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SCAN;
      col_idx     <= 2'd0;
      dwell_cnt   <= '0;
      db_cnt      <= '0;
      row_latch   <= '0;
      key_code_o  <= '0;
      key_valid_o <= 1'b0;
      key_held_o  <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      // An ack consumes the key; it has no effect when nothing is pending.
      // A PRESSED in the same cycle overrides this below, so ack wins and
      // the new key is loaded without an overrun.
      if (key_ack_i) key_valid_o <= 1'b0;

      case (state)
        SCAN: begin
          if (tick) begin
            dwell_cnt <= '0;
            if (row_s == '0) begin
              col_idx <= col_idx + 2'd1;
            end else begin
              state     <= DEBOUNCE;
              row_latch <= row_s;
              db_cnt    <= '0;
            end
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end

        DEBOUNCE: begin
          if (row_s == '0) begin
            state     <= SCAN;
            col_idx   <= col_idx + 2'd1;
            dwell_cnt <= '0;
          end else if (row_s != row_latch) begin
            // A different row pattern restarts the stability window.
            row_latch <= row_s;
            db_cnt    <= '0;
          end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            state <= PRESSED;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end

        PRESSED: begin
          key_held_o  <= 1'b1;
          key_valid_o <= 1'b1;
          if (!key_valid_o || key_ack_i) begin
            key_code_o <= {prio_row(row_latch), col_idx};
          end else begin
            // Unconsumed key is kept; the newer one is dropped and flagged.
            overrun_o <= 1'b1;
          end
          db_cnt <= '0;
          state  <= RELEASE;
        end

        RELEASE: begin
          // Leaves on the DEBOUNCE_CYCLES-th consecutive empty sample, so the
          // counter never needs to hold DEBOUNCE_CYCLES itself.
          if (row_s != '0) begin
            db_cnt <= '0;
          end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            key_held_o <= 1'b0;
            col_idx    <= col_idx + 2'd1;
            dwell_cnt  <= '0;
            state      <= SCAN;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end

        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl (SCAN_DIV=4, DEBOUNCE_CYCLES=8,
// SYNC_STAGES=2). A keypad model returns the pressed row pattern only while
// the key's column is driven. Expected key codes are queued when a press is
// issued; a monitor pops and compares on every rising key_valid_o.
module tb_keypad_scan_ctrl;

  localparam int SCAN_DIV        = 4;
  localparam int DEBOUNCE_CYCLES = 8;
  localparam int SYNC_STAGES     = 2;

  logic       clk = 1'b0;
  logic       rst_n_i;
  logic [3:0] row_i;
  logic [3:0] col_o;
  logic [3:0] key_code_o;
  logic       key_valid_o;
  logic       key_ack_i;
  logic       key_held_o;
  logic       overrun_o;

  always #5 clk = ~clk;

  keypad_scan_ctrl #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) dut (
    .clk         (clk),
    .rst_n_i     (rst_n_i),
    .row_i       (row_i),
    .col_o       (col_o),
    .key_code_o  (key_code_o),
    .key_valid_o (key_valid_o),
    .key_ack_i   (key_ack_i),
    .key_held_o  (key_held_o),
    .overrun_o   (overrun_o)
  );

  // Keypad model
  logic       key_down;
  int         key_col;
  logic [3:0] key_pat;
  logic       raw_mode;
  logic [3:0] raw_val;

  always_comb begin
    row_i = 4'b0000;
    if (raw_mode) row_i = raw_val;
    else if (key_down && col_o[key_col]) row_i = key_pat;
  end

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] exp_q[$];
  logic       prev_valid = 1'b0;
  logic [3:0] seq [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (key_valid_o === 1'b1 && !prev_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_key: got code 0x%0h, expected no key", key_code_o);
      end else begin
        check("key_code", key_code_o, exp_q.pop_front());
      end
    end
    prev_valid = (key_valid_o === 1'b1);
  end

  task automatic wait_col_entry(input logic [3:0] c, input int budget, input string name);
    int k;
    k = 0;
    while (col_o === c && k < budget) begin @(negedge clk); k++; end
    while (col_o !== c && k < budget) begin @(negedge clk); k++; end
    check(name, col_o, c);
  endtask

  task automatic wait_held(input logic v, input int budget, input string name);
    int k;
    k = 0;
    while (key_held_o !== v && k < budget) begin @(negedge clk); k++; end
    check(name, key_held_o, v);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col"},     col_o,       4'b0001);
    check({tag, "_code"},    key_code_o,  4'b0000);
    check({tag, "_valid"},   key_valid_o, 1'b0);
    check({tag, "_held"},    key_held_o,  1'b0);
    check({tag, "_overrun"}, overrun_o,   1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    logic [3:0] c0;
    seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst_n_i   = 1'b0;
    key_ack_i = 1'b0;
    key_down  = 1'b0;
    key_col   = 0;
    key_pat   = 4'b0000;
    raw_mode  = 1'b0;
    raw_val   = 4'b0000;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n_i = 1'b1;

    // 1. Idle scan: each column held for SCAN_DIV cycles, rotating left.
    wait_col_entry(4'b0010, 40, "idle_first_col1");
    for (int k = 0; k < 16; k++) begin
      check("idle_col_seq", col_o, seq[k/4]);
      if (k % 4 == 0) check("idle_valid", key_valid_o, 1'b0);
      @(negedge clk);
    end

    // 2. Row 2 in column 1 -> code 1001, scan frozen while held.
    wait_col_entry(4'b0001, 40, "t2_col0");
    key_col = 1;
    key_pat = 4'b0100;
    exp_q.push_back(4'b1001);
    key_down = 1'b1;
    wait_held(1'b1, 40, "t2_held_rise");
    check("t2_frozen_col", col_o, 4'b0010);
    check("t2_valid", key_valid_o, 1'b1);
    repeat (10) @(negedge clk);
    check("t2_still_frozen", col_o, 4'b0010);
    check("t2_still_held", key_held_o, 1'b1);
    key_ack_i = 1'b1;
    @(negedge clk);
    key_ack_i = 1'b0;
    check("t2_ack_clears_valid", key_valid_o, 1'b0);
    key_down = 1'b0;
    n = 0;
    while (key_held_o && n < 40) begin @(negedge clk); n++; end
    // SYNC_STAGES cycles to see the release, then DEBOUNCE_CYCLES empty samples.
    check("t2_release_delay", n, SYNC_STAGES + DEBOUNCE_CYCLES);
    check("t2_resume_col", col_o, 4'b0100);

    // 3. Bouncing row line never debounces; scanning resumes.
    raw_mode = 1'b1;
    for (int k = 0; k < 20; k++) begin
      raw_val = ((k / 3) % 2 == 0) ? 4'b0001 : 4'b0000;
      @(negedge clk);
    end
    raw_val  = 4'b0000;
    raw_mode = 1'b0;
    repeat (12) @(negedge clk);
    check("t3_no_valid", key_valid_o, 1'b0);
    check("t3_no_held", key_held_o, 1'b0);
    c0 = col_o;
    n = 0;
    while (col_o === c0 && n < 10) begin @(negedge clk); n++; end
    check("t3_scan_resumes", col_o, {c0[2:0], c0[3]});

    // 4. Key 0 unacked, then key 15 -> code kept, overrun set.
    wait_col_entry(4'b1000, 40, "t4_col3");
    key_col = 0;
    key_pat = 4'b0001;
    exp_q.push_back(4'b0000);
    key_down = 1'b1;
    wait_held(1'b1, 40, "t4_key0_held");
    key_down = 1'b0;
    wait_held(1'b0, 40, "t4_key0_released");
    key_col = 3;
    key_pat = 4'b1000;
    key_down = 1'b1;
    wait_held(1'b1, 60, "t4_key15_held");
    check("t4_overrun", overrun_o, 1'b1);
    check("t4_valid_kept", key_valid_o, 1'b1);
    check("t4_code_kept", key_code_o, 4'b0000);
    key_down = 1'b0;
    wait_held(1'b0, 40, "t4_key15_released");
    key_ack_i = 1'b1;
    @(negedge clk);
    key_ack_i = 1'b0;
    check("t4_ack_clears_valid", key_valid_o, 1'b0);
    check("t4_overrun_sticky", overrun_o, 1'b1);

    // Ack with nothing pending is ignored.
    key_ack_i = 1'b1;
    @(negedge clk);
    key_ack_i = 1'b0;
    @(negedge clk);
    check("idle_ack_valid", key_valid_o, 1'b0);
    check("idle_ack_overrun", overrun_o, 1'b1);

    // 5. Rows 1 and 3 in column 1 -> lowest row wins, code 0101.
    wait_col_entry(4'b0001, 40, "t5_col0");
    key_col = 1;
    key_pat = 4'b1010;
    exp_q.push_back(4'b0101);
    key_down = 1'b1;
    wait_held(1'b1, 40, "t5_held");
    check("t5_valid", key_valid_o, 1'b1);
    repeat (3) @(negedge clk);

    // 6a. Reset mid-RELEASE with a pending key.
    #2 rst_n_i = 1'b0;
    #1 check_reset_outputs("t6_release_rst");
    key_down = 1'b0;
    @(negedge clk);
    rst_n_i = 1'b1;
    @(negedge clk);
    check("t6_col_after_release", col_o, 4'b0001);

    // 6b. Reset mid-DEBOUNCE.
    wait_col_entry(4'b0001, 40, "t6_col0");
    key_col = 0;
    key_pat = 4'b0010;
    key_down = 1'b1;
    repeat (7) @(negedge clk);
    check("t6_debounce_frozen", col_o, 4'b0001);
    check("t6_debounce_not_held", key_held_o, 1'b0);
    #2 rst_n_i = 1'b0;
    #1 check_reset_outputs("t6_debounce_rst");
    key_down = 1'b0;
    @(negedge clk);
    rst_n_i = 1'b1;
    repeat (2) @(negedge clk);
    check("t6b_col_after_release", col_o, 4'b0001);
    wait_col_entry(4'b0010, 20, "t6_scan_resumes");
    repeat (10) @(negedge clk);
    check("final_valid", key_valid_o, 1'b0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
